// File: rtl/pq_alu_pkg.sv
// Shared types and sizing for the PQ-ALU vector datapath.
package pq_alu_pkg;

    localparam int WLEN       = 256;
    localparam int DATA_WIDTH = 32;
    localparam int LANES      = WLEN / DATA_WIDTH;
    localparam int LANE_CNT_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_SUB = 1'b0,
        OP_ADD = 1'b1
    } op_e;

endpackage

// File: rtl/pq_lane_addsub.sv
// Single-lane modular add/sub with one conditional correction; operands are
// expected below q, and out-of-range inputs simply wrap at DATA_WIDTH bits.
module pq_lane_addsub #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] q,
    input  logic                  op,
    output logic [DATA_WIDTH-1:0] r
);
    import pq_alu_pkg::*;

    logic [DATA_WIDTH-1:0] w_t_add;
    logic [DATA_WIDTH-1:0] w_t_sub;

    assign w_t_add = a + b;
    // Adding q first keeps the subtraction non-negative for in-range operands.
    assign w_t_sub = (a + q) - b;

    always_comb begin
        r = '0;
        if (op == OP_ADD) begin
            r = (w_t_add >= q) ? (w_t_add - q) : w_t_add;
        end else begin
            r = (w_t_sub < q) ? w_t_sub : (w_t_sub - q);
        end
    end

endmodule

// File: rtl/pq_vec_modaddsub_seq.sv
// Vector modular add/sub sequencer: latches one request, streams the lanes
// through a shared lane unit one per cycle, then presents the packed result.
//
// state | meaning
// IDLE  | ready for a request; result register holds the previous vector
// RUN   | one lane computed and written per cycle, LANES cycles total
// DONE  | result valid, waiting for the consumer handshake
module pq_vec_modaddsub_seq #(
    parameter int WLEN       = pq_alu_pkg::WLEN,
    parameter int DATA_WIDTH = pq_alu_pkg::DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  op_i,
    input  logic [WLEN-1:0]       a_i,
    input  logic [WLEN-1:0]       b_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WLEN-1:0]       res_o,
    output logic                  busy_o
);
    import pq_alu_pkg::*;

    localparam int LANES = WLEN / DATA_WIDTH;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [WLEN-1:0]       r_a;
    logic [WLEN-1:0]       r_b;
    logic [WLEN-1:0]       r_res;
    logic [DATA_WIDTH-1:0] r_q;
    op_e                   r_op;

    logic [DATA_WIDTH-1:0] w_a_lane;
    logic [DATA_WIDTH-1:0] w_b_lane;
    logic [DATA_WIDTH-1:0] w_r_lane;
    logic                  w_last;

    assign w_a_lane = r_a[r_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign w_b_lane = r_b[r_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign w_last   = (r_cnt == CNT_W'(LANES - 1));

    pq_lane_addsub #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
        .a  (w_a_lane),
        .b  (w_b_lane),
        .q  (r_q),
        .op (r_op),
        .r  (w_r_lane)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_op    <= OP_SUB;
            r_res   <= '0;
        end else if (clear_i) begin
            // Abort wins over accept and handshake; the result register is kept.
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_q     <= q_i;
                        r_op    <= op_e'(op_i);
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= w_r_lane;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (r_state == IDLE);
    assign out_valid_o = (r_state == DONE);
    assign busy_o      = (r_state != IDLE);
    assign res_o       = r_res;

endmodule

// File: tb/tb_pq_vec_modaddsub_seq.sv
// Directed and random bench for the vector modular add/sub sequencer, with a
// scoreboard of expected packed results checked at each output handshake.
module tb_pq_vec_modaddsub_seq;
    localparam int WLEN  = 256;
    localparam int DW    = 32;
    localparam int LANES = WLEN / DW;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            clear_i = 1'b0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic            op_i = 1'b0;
    logic [WLEN-1:0] a_i = '0;
    logic [WLEN-1:0] b_i = '0;
    logic [DW-1:0]   q_i = '0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [WLEN-1:0] res_o;
    logic            busy_o;

    int total = 0;
    int bad   = 0;
    logic [WLEN-1:0] sb[$];

    pq_vec_modaddsub_seq dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .q_i         (q_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .res_o       (res_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [WLEN-1:0] obs, input logic [WLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // True modular reference (operands assumed below q).
    function automatic logic [DW-1:0] lane_ref(input bit op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b, input logic [DW-1:0] q);
        longint la, lb, lq, r;
        la = longint'(a); lb = longint'(b); lq = longint'(q);
        if (op) r = (la + lb) % lq;
        else    r = (la - lb + lq) % lq;
        return r[DW-1:0];
    endfunction

    function automatic logic [WLEN-1:0] vec_ref(input bit op, input logic [WLEN-1:0] a,
                                                input logic [WLEN-1:0] b, input logic [DW-1:0] q);
        logic [WLEN-1:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++)
            v[k*DW +: DW] = lane_ref(op, a[k*DW +: DW], b[k*DW +: DW], q);
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit op, input logic [WLEN-1:0] a, input logic [WLEN-1:0] b,
                        input logic [DW-1:0] q);
        int n;
        op_i = op; a_i = a; b_i = b; q_i = q; in_valid_i = 1'b1;
        n = 0;
        while (!in_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("send_ready", in_ready_o, 1);
        @(posedge clk_i);
        sb.push_back(vec_ref(op, a, b, q));
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic recv(input string tag);
        int n;
        logic [WLEN-1:0] exp;
        n = 0;
        while (!out_valid_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_valid"}, out_valid_o, 1);
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        chk({tag, "_res"}, res_o, exp);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        out_ready_i = 1'b0;
        chk({tag, "_drop"}, out_valid_o, 0);
    endtask

    function automatic logic [WLEN-1:0] splat(input logic [DW-1:0] x);
        logic [WLEN-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*DW +: DW] = x;
        return v;
    endfunction

    initial begin
        logic [WLEN-1:0] va, vb, exp_v;
        logic [DW-1:0] rq;
        int n;
        bit rop;

        #12;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_res", res_o, '0);
        chk("rst_busy", busy_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_in_ready", in_ready_o, 1);

        // SUB q=3329, a=5, b=10 -> 3324 each lane, with latency measurement
        send(1'b0, splat(32'd5), splat(32'd10), 32'd3329);
        chk("run_busy", busy_o, 1);
        chk("run_in_ready", in_ready_o, 0);
        n = 1;
        while (!out_valid_o && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        chk("latency", 32'(n), 32'd9);
        chk("sub_3324_const", res_o, splat(32'd3324));
        recv("sub_small");

        // ADD lane k: a=3000+k, b=400 -> 71+k
        for (int k = 0; k < LANES; k++) begin
            va[k*DW +: DW] = 32'(3000 + k);
            exp_v[k*DW +: DW] = 32'(71 + k);
        end
        send(1'b1, va, splat(32'd400), 32'd3329);
        n = 0;
        while (!out_valid_o && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        chk("add_wrap_const", res_o, exp_v);
        recv("add_wrap");

        send(1'b0, splat(32'd1234), splat(32'd1234), 32'd3329);
        recv("sub_equal");

        // Back-pressure, then a second request queued behind the handshake
        send(1'b1, splat(32'd100), splat(32'd200), 32'd3329);
        n = 0;
        while (!out_valid_o && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", out_valid_o, 1);
            chk("bp_res", res_o, splat(32'd300));
            chk("bp_in_ready", in_ready_o, 0);
            @(negedge clk_i);
        end
        out_ready_i = 1'b1;
        op_i = 1'b0; a_i = splat(32'd7); b_i = splat(32'd9); q_i = 32'd3329; in_valid_i = 1'b1;
        exp_v = sb.pop_front();
        chk("bp_final_res", res_o, exp_v);
        @(posedge clk_i);
        @(negedge clk_i);
        out_ready_i = 1'b0;
        chk("bp_drop", out_valid_o, 0);
        chk("bp_next_ready", in_ready_o, 1);
        @(posedge clk_i);
        sb.push_back(vec_ref(1'b0, splat(32'd7), splat(32'd9), 32'd3329));
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("bp_next_busy", busy_o, 1);
        recv("bp_next");

        // clear_i during RUN cycle 3
        send(1'b1, splat(32'd1), splat(32'd2), 32'd3329);
        void'(sb.pop_back());
        @(negedge clk_i);
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("clr_busy", busy_o, 0);
        chk("clr_in_ready", in_ready_o, 1);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid_o) n++;
            @(negedge clk_i);
        end
        chk("clr_no_valid", 32'(n), 32'd0);

        // clear_i with in_valid_i in IDLE: nothing latched
        op_i = 1'b1; a_i = splat(32'd3); b_i = splat(32'd4); q_i = 32'd3329;
        in_valid_i = 1'b1;
        clear_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        clear_i = 1'b0;
        chk("clr_accept_busy", busy_o, 0);
        @(negedge clk_i);
        chk("clr_accept_ready", in_ready_o, 1);

        // Asynchronous reset mid-RUN
        send(1'b1, splat(32'd11), splat(32'd22), 32'd3329);
        void'(sb.pop_back());
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_out_valid", out_valid_o, 0);
        chk("arst_res", res_o, '0);
        chk("arst_in_ready", in_ready_o, 1);
        chk("arst_busy", busy_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        send(1'b1, splat(32'd11), splat(32'd22), 32'd3329);
        recv("post_rst");

        // Boundary lanes at q=8380417
        send(1'b0, splat(32'd0), splat(32'd8380416), 32'd8380417);
        n = 0;
        while (!out_valid_o && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        chk("bnd_sub_const", res_o, splat(32'd1));
        recv("bnd_sub");
        send(1'b1, splat(32'd8380416), splat(32'd8380416), 32'd8380417);
        n = 0;
        while (!out_valid_o && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        chk("bnd_add_const", res_o, splat(32'd8380415));
        recv("bnd_add");

        // Random vectors: 1250 x 8 lanes = 10k lane results
        for (int v = 0; v < 1250; v++) begin
            case (v % 3)
                0: rq = 32'd3329;
                1: rq = 32'd8380417;
                default: rq = 32'($urandom_range(32'h7FFF_FFFF, 2));
            endcase
            for (int k = 0; k < LANES; k++) begin
                va[k*DW +: DW] = 32'($urandom_range(rq - 1, 0));
                vb[k*DW +: DW] = 32'($urandom_range(rq - 1, 0));
            end
            rop = 1'($urandom_range(1, 0));
            send(rop, va, vb, rq);
            recv("rand");
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
